// File: rtl/proc_pkg.sv
// proc_pkg: shared front-end widths and a portable ceil-log2 helper
package proc_pkg;

    localparam int INS_WIDTH = 16;
    localparam int TS_WIDTH  = 16;

    // Written as a loop so tools that handle $clog2 inconsistently in
    // parameter contexts still produce the same constant.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ins_prefetch_queue_if.sv
// ins_prefetch_queue_if: source-side and decode-side handshakes of the prefetch queue
interface ins_prefetch_queue_if import proc_pkg::*; #(
    parameter int WIDTH = INS_WIDTH,
    parameter int NSRC  = 2
);

    logic [clog2(NSRC)-1:0] src_sel;
    logic [NSRC*WIDTH-1:0]  ins_in;
    logic [NSRC-1:0]        in_valid;
    logic [NSRC-1:0]        in_ready;
    logic [WIDTH-1:0]       ins_out;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output src_sel, ins_in, in_valid, out_ready,
        input  in_ready, ins_out, out_valid
    );

    modport slave (
        input  src_sel, ins_in, in_valid, out_ready,
        output in_ready, ins_out, out_valid
    );

endinterface

// File: rtl/ins_fifo_core.sv
// ins_fifo_core: power-of-2 FIFO storage with pointers, occupancy count and clear
module ins_fifo_core import proc_pkg::*; #(
    parameter int WIDTH = INS_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        valid,
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage needs no reset; only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at DEPTH; count alone distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign valid = count != '0;
    assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ins_prefetch_queue.sv
// ins_prefetch_queue: source-selecting instruction FIFO with a held exception record
module ins_prefetch_queue import proc_pkg::*; #(
    parameter int WIDTH = INS_WIDTH,
    parameter int DEPTH = 4,
    parameter int NSRC  = 2,
    parameter int TW    = TS_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    ins_prefetch_queue_if.slave         bus,
    input  logic                        flush,
    input  logic                        save_excp,
    input  logic [TW-1:0]               time_in,
    input  logic                        excp_ack,
    output logic                        excp_pend,
    output logic [WIDTH-1:0]            excp_ins,
    output logic [TW-1:0]               excp_time,
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int SW = clog2(NSRC);
    localparam int CW = clog2(DEPTH+1);

    logic [WIDTH-1:0] sel_word;
    logic             sel_valid;
    logic [NSRC-1:0]  ready;
    logic             clear;
    logic             accept;
    logic             push;
    logic             pop;

    assign clear  = flush || save_excp;
    assign accept = (count != CW'(DEPTH)) && !clear;
    assign push   = sel_valid && accept;
    assign pop    = bus.out_valid && bus.out_ready && !clear;

    // Source mux and ready: only the selected source sees ready; an
    // out-of-range select matches no source and so stalls everything.
    always_comb begin
        sel_word  = '0;
        sel_valid = 1'b0;
        ready     = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.src_sel == SW'(k)) begin
                sel_word  = bus.ins_in[k*WIDTH +: WIDTH];
                sel_valid = bus.in_valid[k];
                ready[k]  = accept;
            end
        end
    end

    assign bus.in_ready = ready;

    ins_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (sel_word),
        .dout  (bus.ins_out),
        .valid (bus.out_valid),
        .count (count)
    );

    // First exception wins until acknowledged; ack in the same cycle frees the slot for a new capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excp_pend <= 1'b0;
            excp_ins  <= '0;
            excp_time <= '0;
        end else if (save_excp && (!excp_pend || excp_ack)) begin
            excp_pend <= 1'b1;
            excp_ins  <= bus.ins_out;
            excp_time <= time_in;
        end else if (excp_ack) begin
            excp_pend <= 1'b0;
        end
    end

endmodule

// File: doc/ins_prefetch_queue.md
Name: ins_prefetch_queue

Overview:
- Parametrised instruction input stage for the processor front end. Successor to the single-register instruction buffer and two-way instruction selector.
- Selects one of NSRC instruction sources and queues the words in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- On an exception it captures the head instruction and a timestamp into a held exception record, and flushes the queue.
- Sits between the instruction memory/ROM ports and the decode stage.

Parameters:
- WIDTH, 16: instruction word width in bits.
- DEPTH, 4: FIFO entries. Must be a power of 2 and at least 2.
- NSRC, 2: number of instruction sources. Must be at least 2.
- TW, 16: timestamp width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_sel  in  $clog2(NSRC)  index of the active source.
- ins_in  in  NSRC*WIDTH  flattened source words; source k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  NSRC  per-source valid.
- in_ready  out  NSRC  per-source ready.
- ins_out  out  WIDTH  head instruction.
- out_valid  out  1  queue is non-empty.
- out_ready  in  1  decode accepts the head.
- flush  in  1  discard all queued words.
- save_excp  in  1  capture an exception record.
- time_in  in  TW  timestamp sampled on capture.
- excp_ack  in  1  release the exception record.
- excp_pend  out  1  an exception record is held.
- excp_ins  out  WIDTH  captured instruction.
- excp_time  out  TW  captured timestamp.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - pointers and count go to 0; out_valid=0; ins_out=0;
  - excp_pend=0, excp_ins=0, excp_time=0;
  - storage contents are don't-care.
- Ready (combinational):
  - in_ready[src_sel] = (count != DEPTH) && !flush && !save_excp;
  - every other in_ready bit is 0.
  - src_sel may change on any cycle and takes effect in the same cycle.
  - A src_sel value >= NSRC selects nothing: all in_ready=0.
- Push: in_valid[src_sel] && in_ready[src_sel].
  - mem[wr_ptr] <= selected word; wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready && !flush && !save_excp.
  - rd_ptr increments modulo DEPTH.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
  - When full, push is blocked by ready, so no simultaneous push/pop at DEPTH.
- Output:
  - out_valid = (count != 0);
  - ins_out = mem[rd_ptr] when out_valid, else 0;
  - both are driven from registered state with no combinational path from ins_in.
- Latency: a word pushed into an empty queue appears on ins_out on the next cycle. Sustained throughput is 1 word/cycle.
- Flush: next cycle has count=0 and rd_ptr=wr_ptr=0. Any push or pop in the flush cycle is ignored.
- save_excp, when excp_pend=0 or excp_ack=1 in the same cycle:
  - excp_ins <= out_valid ? ins_out : 0;
  - excp_time <= time_in;
  - excp_pend <= 1;
  - the queue is flushed exactly as for flush.
- save_excp while excp_pend=1 and excp_ack=0:
  - the record is NOT overwritten (first exception wins);
  - the queue is still flushed.
- excp_ack alone clears excp_pend the next cycle; excp_ins and excp_time hold their values.
- flush and save_excp together behave as save_excp.
- Pointer wrap-around: DEPTH is a power of 2, so pointers are $clog2(DEPTH) bits and wrap naturally. count tracks full/empty.

Decomposition:
- Shared package (proc_pkg): default INS_WIDTH=16, TS_WIDTH=16, and a clog2 helper constant function for tool portability.
- One natural sub-module: ins_fifo_core (storage, pointers, count, push/pop/flush).
  - The top level holds the source mux, ready generation and the exception capture register.

Test Plan:
- Reset mid-traffic: assert rst with count=3 -> out_valid=0, count=0, ins_out=0 and excp_pend=0 immediately, asynchronously.
- Fill and drain, DEPTH=4, src_sel=0: push 0x1111, 0x2222, 0x3333, 0x4444 with out_ready=0 -> count=4, in_ready[0]=0; a fifth push is ignored. Then out_ready=1 -> outputs 0x1111..0x4444 in order, one per cycle, then out_valid=0.
- Source switch: src_sel=1 with ins_in source1=0xABCD and in_valid=2'b11 -> only in_ready[1]=1, and 0xABCD is queued; source0's word 0x0000 is never queued.
- Simultaneous push/pop at count=2 over 10 cycles -> count stays 2, pointers wrap past 3→0, and ordering is preserved.
- Exception: head 0x5A5A, time_in=0x0100, save_excp=1 -> next cycle excp_pend=1, excp_ins=0x5A5A, excp_time=0x0100, count=0. A second save_excp with time_in=0x0200 -> record unchanged. excp_ack -> excp_pend=0.
- Ack and save in the same cycle with excp_pend=1, empty queue, time_in=0x0300 -> excp_pend stays 1, excp_ins=0, excp_time=0x0300.
